mux8_rr_arbiter: RTL
====================

# mux8_rr_arbiter

Round-robin arbiter that shares one 8:1 one-bit selector among eight requesters. It converts per-requester request lines into a registered one-hot grant and a 3-bit select, and routes the granted requester's data bit to the shared output `F`. A hold limit bounds each grant so no requester can starve the others. It sits in front of the `mux8_1cond` / `mux8_1logic` selectors and drives their `Sel` input.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles one grant may last; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request lines; `req[i]` high means requester i wants the selector.
- `A`  in  8  data bits; `A[i]` belongs to requester i.
- `gnt`  out  8  registered one-hot grant; all-zero when nothing is granted.
- `Sel`  out  3  registered index of the current or most recent grant; feeds the shared 8:1 selector.
- `valid`  out  1  registered; high while a grant is active.
- `F`  out  1  combinational `valid & A[Sel]`.

## Operation
- State: `IDLE`/`GRANT`, priority pointer `ptr[2:0]`, hold counter `hcnt` (8 bits).
- Reset values: state `IDLE`, `ptr`=0, `Sel`=0, `gnt`=0, `valid`=0, `hcnt`=0. This makes `F`=0.
- Arbitration function: search `ptr, ptr+1, …, ptr+7` (mod 8) and pick the first i with `req[i]`=1.
- **IDLE**
  - If `req`≠0, the next edge loads `Sel`=winner, `gnt`=1<<winner, `valid`=1, `hcnt`=1 and moves to `GRANT`.
  - Otherwise all outputs hold; `Sel` keeps its last value.
- **GRANT**: the grant is released at an edge where `req[Sel]`=0 or `hcnt`==`MAX_HOLD`.
  - Otherwise the grant holds and `hcnt` increments.
  - On release, `ptr` becomes `Sel`+1 (mod 8; 7 wraps to 0). Arbitration is evaluated in the same cycle using that new pointer value.
  - If any `req` is high on release, the winner is loaded directly. `hcnt`=1, state stays `GRANT`, and no idle cycle is inserted.
  - If the released requester is the only one requesting (forced release by `MAX_HOLD`), it is re-granted, because the search reaches it last.
  - If `req`=0 on release: `gnt`=0, `valid`=0, and state goes to `IDLE`.
- Requests rising while a grant is held have no effect until release; there is no preemption.
- `gnt` is always zero or exactly one-hot. When `valid`=1, `gnt`==1<<`Sel`.
- **Reset mid-grant**: at the next edge all registers return to reset values, regardless of `req`.
- **`MAX_HOLD`=1**: every grant lasts exactly one cycle, and requesters rotate each cycle.

## Timing
- Request-to-grant latency: 1 cycle. `req` is sampled at edge n, and `gnt`/`Sel`/`valid` are visible after edge n.
- Release latency: 1 cycle after `req[Sel]` falls, or after `hcnt` reaches `MAX_HOLD` (the grant lasts exactly `MAX_HOLD` cycles).
- Grant-to-grant switch: 0 bubble cycles.
- `F` has 0-cycle latency from `A` and follows registered `Sel`/`valid`; it is never glitched by `req` changes within a cycle.
- Worst-case wait for a continuously asserted request: 7×`MAX_HOLD` cycles + 1.

## Test plan
- **Reset**: hold `rst`=1 for 2 cycles with `req`=8'hFF.
  - Required: `gnt`=0, `Sel`=0, `valid`=0, `F`=0 throughout.
  - After release: `gnt`=8'h01 one cycle later.
- **Single requester and data path**: `req`=8'h08.
  - Required: next cycle `gnt`=8'h08, `Sel`=3, `valid`=1.
  - Sweep `A` through 0..255: `F`==`A[3]` every cycle.
  - Drop `req`: `valid`=0 and `gnt`=0 one cycle later.
- **Full contention**: `req`=8'hFF from reset; each requester drops its bit 2 cycles after being granted.
  - Required: grant order 0,1,2,…,7 with no gap cycles.
  - Then `valid`=0.
- **Hold limit**: `MAX_HOLD`=16, `req[5]` held permanently, `req[6]` raised 3 cycles later.
  - Required: `gnt`=8'h20 for exactly 16 cycles, then `gnt`=8'h40 with no bubble.
- **Wrap-around**: the last released grant is 7 (`ptr`=0) and `req`=8'h81.
  - Required: grant 0 first, then 7 after release.
  - Sole requester with `MAX_HOLD` expiry: re-granted with `hcnt` restarting at 1.
- **Reset mid-grant**: assert `rst` while `gnt`=8'h10.
  - Required: `gnt`=0, `valid`=0, `Sel`=0 at the next edge.
  - After reset deasserts with `req`=8'h30: `gnt`=8'h10 (pointer reset to 0).

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 one-bit selector: registered one-hot
// grant and select with a bounded hold time, and the granted data bit on F.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] A,
  output logic [7:0] gnt,
  output logic [2:0] Sel,
  output logic       valid,
  output logic       F,
  output logic       dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic [7:0] hcnt_q, hcnt_d;

  logic [2:0] pick_ptr;
  logic [2:0] winner;
  logic       release_now;

  // First requester at or after p, walking upward modulo 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // On release the search starts just past the outgoing owner, in the same cycle.
  assign pick_ptr    = (state_q == GRANT) ? sel_q + 3'd1 : ptr_q;
  assign winner      = rr_pick(req, pick_ptr);
  assign release_now = !req[sel_q] || (hcnt_q == 8'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      IDLE: begin
        if (req != 8'd0) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = 8'b1 << winner;
          valid_d = 1'b1;
          hcnt_d  = 8'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = sel_q + 3'd1;
          if (req != 8'd0) begin
            sel_d  = winner;
            gnt_d  = 8'b1 << winner;
            hcnt_d = 8'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
            valid_d = 1'b0;
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
      valid_q <= 1'b0;
      hcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign Sel         = sel_q;
  assign valid       = valid_q;
  assign F           = valid_q & A[sel_q];
  assign dbg_state_o = state_q;

endmodule
